led_pattern_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 25 ++
 rtl/led_pattern_ram.sv | 28 ++
 rtl/led_pattern_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// LED pattern sequencer shared types: FSM state encoding, config validity rules, default target.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    // A pattern needs at least one word; WAIT must last at least one cycle.
    localparam int unsigned LEN_MIN    = 1;
    localparam int unsigned PERIOD_MIN = 1;

    // Word index of the LED input register in the register block.
    localparam int unsigned DEFAULT_LED_ADDR = 0;

    // A START is only honoured when the requested length fits the RAM and the interval is non-zero.
    function automatic logic cfg_valid(input int unsigned len, input int unsigned period,
                                       input int unsigned depth);
        return (len >= LEN_MIN) && (len <= depth) && (period >= PERIOD_MIN);
    endfunction

endpackage

// File: rtl/led_pattern_ram.sv
// Pattern storage: DEPTH x DATA_WIDTH words, one synchronous write port, one asynchronous read port.
// Latency: write lands on the next CLK edge; read is combinational from the index.
// Backpressure: none; every write is accepted.
module led_pattern_ram #(
    parameter int unsigned  DEPTH      = 8,
    parameter int unsigned  DATA_WIDTH = 32,
    localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; software loads the pattern before starting.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/led_pattern_sequencer.sv
// Plays a stored pattern into the LED register at a programmable interval and shares the write port with the host.
// Latency: first write the cycle after an accepted START; writes spaced PERIOD+1 cycles apart.
// Backpressure: host writes have strict priority; each host write stalls a pending sequencer write by one cycle.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH   = 32,
    parameter int unsigned          ADDR_WIDTH   = 4,
    parameter int unsigned          DEPTH        = 8,
    parameter int unsigned          PERIOD_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] LED_ADDR    = ADDR_WIDTH'(DEFAULT_LED_ADDR),
    localparam int unsigned         IDX_W        = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic [ADDR_WIDTH-1:0]   H_WADDR,
    input  logic [DATA_WIDTH-1:0]   H_WDATA,
    input  logic                    H_WVALID,
    output logic                    H_WERROR,
    input  logic                    PAT_WE,
    input  logic [IDX_W-1:0]        PAT_WADDR,
    input  logic [DATA_WIDTH-1:0]   PAT_WDATA,
    input  logic                    CFG_START,
    input  logic                    CFG_STOP,
    input  logic                    CFG_LOOP,
    input  logic [IDX_W:0]          CFG_LEN,
    input  logic [PERIOD_WIDTH-1:0] CFG_PERIOD,
    output logic [ADDR_WIDTH-1:0]   WADDR,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic                    WVALID,
    input  logic                    WERROR,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERROR,
    output logic [IDX_W-1:0]        STEP
);

    localparam logic [IDX_W:0]        C_LEN_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0]      C_STEP_ONE = IDX_W'(1);
    localparam logic [PERIOD_WIDTH-1:0] C_CNT_ONE = PERIOD_WIDTH'(1);

    seq_state_t              r_state;
    seq_state_t              w_state_nxt;
    logic [IDX_W-1:0]        r_step;
    logic [IDX_W:0]          r_len;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic                    r_loop;
    logic [PERIOD_WIDTH-1:0] r_cnt;

    logic                    w_start_ok;
    logic                    w_seq_wr;
    logic                    w_last;
    logic                    w_cnt_end;
    logic                    w_done;
    logic                    w_error;
    logic [DATA_WIDTH-1:0]   w_pat_rdata;

    led_pattern_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .CLK     (CLK),
        .i_we    (PAT_WE),
        .i_waddr (PAT_WADDR),
        .i_wdata (PAT_WDATA),
        .i_raddr (r_step),
        .o_rdata (w_pat_rdata)
    );

    assign w_start_ok = CFG_START && cfg_valid(32'(CFG_LEN), 32'(CFG_PERIOD), DEPTH);
    // The sequencer only owns the port in ISSUE cycles the host leaves free.
    assign w_seq_wr   = (r_state == ISSUE) && !H_WVALID;
    assign w_last     = ({1'b0, r_step} == (r_len - C_LEN_ONE));
    assign w_cnt_end  = (r_cnt == C_CNT_ONE);

    // State register; reset forces IDLE immediately so no write is left driving the port.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the one-cycle DONE/ERROR pulses; STOP overrides everything, including pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_seq_wr) begin
                    if (WERROR) begin
                        w_state_nxt = IDLE;
                        w_error     = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (w_cnt_end) begin
                    if (w_last && !r_loop) begin
                        w_state_nxt = IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (CFG_STOP) begin
            w_state_nxt = IDLE;
            w_done      = 1'b0;
            w_error     = 1'b0;
        end
    end

    // Step index, latched configuration and interval counter; config is only captured from IDLE.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_step   <= '0;
            r_len    <= '0;
            r_period <= '0;
            r_loop   <= 1'b0;
            r_cnt    <= '0;
        end else if (CFG_STOP) begin
            r_step <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_len    <= CFG_LEN;
                        r_period <= CFG_PERIOD;
                        r_loop   <= CFG_LOOP;
                        r_step   <= '0;
                    end
                end
                ISSUE: begin
                    if (w_seq_wr && !WERROR) begin
                        r_cnt <= r_period;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - C_CNT_ONE;
                    if (w_cnt_end && !(w_last && !r_loop)) begin
                        r_step <= w_last ? '0 : (r_step + C_STEP_ONE);
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-port mux: host first, then the sequencer's ISSUE write, otherwise an idle (zeroed) port.
    always_comb begin
        WADDR    = '0;
        WDATA    = '0;
        WVALID   = 1'b0;
        H_WERROR = 1'b0;
        if (H_WVALID) begin
            WADDR    = H_WADDR;
            WDATA    = H_WDATA;
            WVALID   = 1'b1;
            H_WERROR = WERROR;
        end else if (r_state == ISSUE) begin
            WADDR  = LED_ADDR;
            WDATA  = w_pat_rdata;
            WVALID = 1'b1;
        end
    end

    // BUSY falls in the very cycle a completion or error pulse is raised.
    assign BUSY  = (r_state != IDLE) && !w_done && !w_error;
    assign DONE  = w_done;
    assign ERROR = w_error;
    assign STEP  = r_step;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed scenarios plus randomized traffic.
// Latency: reference model schedules writes by absolute cycle number.
// Backpressure: host writes injected directly; downstream error decided by a register-map size.
module tb_led_pattern_sequencer;

    localparam logic [3:0] LED = 4'd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  h_waddr;
    logic [31:0] h_wdata;
    logic        h_wvalid;
    logic        h_werror;
    logic        pat_we;
    logic [2:0]  pat_waddr;
    logic [31:0] pat_wdata;
    logic        cfg_start, cfg_stop, cfg_loop;
    logic [3:0]  cfg_len;
    logic [15:0] cfg_period;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        wvalid;
    logic        werror;
    logic        busy, done, error;
    logic [2:0]  step;

    // Downstream register block: indices at or beyond map_size reject the write.
    logic [4:0]  map_size;
    always_comb werror = wvalid && ({1'b0, waddr} >= map_size);

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(8), .PERIOD_WIDTH(16), .LED_ADDR(LED)
    ) dut (
        .CLK(clk), .RESETn(rst_n),
        .H_WADDR(h_waddr), .H_WDATA(h_wdata), .H_WVALID(h_wvalid), .H_WERROR(h_werror),
        .PAT_WE(pat_we), .PAT_WADDR(pat_waddr), .PAT_WDATA(pat_wdata),
        .CFG_START(cfg_start), .CFG_STOP(cfg_stop), .CFG_LOOP(cfg_loop),
        .CFG_LEN(cfg_len), .CFG_PERIOD(cfg_period),
        .WADDR(waddr), .WDATA(wdata), .WVALID(wvalid), .WERROR(werror),
        .BUSY(busy), .DONE(done), .ERROR(error), .STEP(step)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0;

    // Reference model state: the pattern, and an absolute-time schedule of the next event.
    logic [31:0] m_pat [8];
    bit m_active, m_final, m_loop;
    int m_step, m_pend, m_due, m_done_at, m_len, m_period;

    int wr_cyc[$];
    logic [31:0] wr_dat[$];
    int done_q[$];
    int err_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic idle_inputs();
        h_wvalid = 1'b0; h_waddr = '0; h_wdata = '0;
        pat_we = 1'b0; pat_waddr = '0; pat_wdata = '0;
        cfg_start = 1'b0; cfg_stop = 1'b0;
    endtask

    task automatic model_reset();
        m_active = 0; m_final = 0; m_step = 0; m_pend = 0;
        m_due = 0; m_done_at = 0;
    endtask

    task automatic clear_logs();
        wr_cyc.delete(); wr_dat.delete(); done_q.delete(); err_q.delete();
    endtask

    // One clock cycle: compare all outputs at the falling edge, advance the model, step past the rising edge.
    task automatic tick();
        bit e_vld, e_herr, e_done, e_err, e_busy, seq_wr, werr_seq;
        logic [3:0]  e_addr;
        logic [31:0] e_data;
        @(negedge clk);
        e_vld = 0; e_herr = 0; e_addr = '0; e_data = '0;
        seq_wr = m_active && !m_final && (cyc >= m_due) && !h_wvalid;
        if (h_wvalid) begin
            e_vld = 1; e_addr = h_waddr; e_data = h_wdata;
            e_herr = ({1'b0, h_waddr} >= map_size);
        end else if (seq_wr) begin
            e_vld = 1; e_addr = LED; e_data = m_pat[m_step];
        end
        werr_seq = seq_wr && ({1'b0, LED} >= map_size);
        e_err  = werr_seq && !cfg_stop;
        e_done = m_active && m_final && (cyc == m_done_at) && !cfg_stop;
        e_busy = m_active && !e_done && !e_err;
        chk("wvalid", 32'(wvalid), 32'(e_vld));
        chk("waddr", 32'(waddr), 32'(e_addr));
        chk("wdata", wdata, e_data);
        chk("h_werror", 32'(h_werror), 32'(e_herr));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("error", 32'(error), 32'(e_err));
        chk("step", 32'(step), 32'(m_step));
        if (wvalid) begin wr_cyc.push_back(cyc); wr_dat.push_back(wdata); end
        if (done) done_q.push_back(cyc);
        if (error) err_q.push_back(cyc);
        if (cfg_stop) begin
            m_active = 0; m_step = 0;
        end else if (m_active) begin
            if (seq_wr) begin
                if (werr_seq) m_active = 0;
                else if (m_step == m_len - 1 && !m_loop) begin
                    m_final = 1; m_done_at = cyc + m_period;
                end else begin
                    m_pend = (m_step == m_len - 1) ? 0 : m_step + 1;
                    m_due  = cyc + m_period + 1;
                end
            end else if (m_final && cyc == m_done_at) begin
                m_active = 0;
            end
            if (m_active && !m_final && cyc + 1 == m_due) m_step = m_pend;
        end else if (cfg_start && cfg_len >= 1 && cfg_len <= 8 && cfg_period != 0) begin
            m_active = 1; m_final = 0; m_step = 0; m_pend = 0; m_due = cyc + 1;
            m_len = int'(cfg_len); m_period = int'(cfg_period); m_loop = cfg_loop;
        end
        if (pat_we) m_pat[pat_waddr] = pat_wdata;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_wr(input string tag, input int i, input int off, input logic [31:0] d);
        if (wr_cyc.size() > i) begin
            chk({tag, "_time"}, 32'(wr_cyc[i] - t0), 32'(off));
            chk({tag, "_data"}, wr_dat[i], d);
        end else begin
            chk({tag, "_count"}, 32'(wr_cyc.size()), 32'(i + 1));
        end
    endtask

    task automatic start_cfg(input int len, input int period, input bit loop_en);
        cfg_len = 4'(len); cfg_period = 16'(period); cfg_loop = loop_en;
        clear_logs();
        t0 = cyc;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        idle_inputs();
        cfg_loop = 0; cfg_len = '0; cfg_period = '0;
        map_size = 5'd3;
        model_reset();
        rst_n = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        h_wvalid = 1'b1; h_waddr = 4'd2; h_wdata = 32'h5A5A_0001;
        #1;
        chk("rst_host_wvalid", 32'(wvalid), 32'd1);
        chk("rst_host_wdata", wdata, 32'h5A5A_0001);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load the pattern: first three entries are the walking-one pattern.
        for (int i = 0; i < 8; i++) begin
            pat_we = 1'b1; pat_waddr = 3'(i);
            pat_wdata = (i < 3) ? (32'd1 << i) : $urandom;
            tick();
        end
        pat_we = 1'b0;
        run(2);

        // One-shot playback.
        start_cfg(3, 2, 0);
        run(12);
        chk("A_nwr", 32'(wr_cyc.size()), 32'd3);
        chk_wr("A_w0", 0, 1, 32'h01);
        chk_wr("A_w1", 1, 4, 32'h02);
        chk_wr("A_w2", 2, 7, 32'h04);
        chk("A_ndone", 32'(done_q.size()), 32'd1);
        if (done_q.size() == 1) chk("A_done_time", 32'(done_q[0] - t0), 32'd9);

        // Looping playback, aborted by STOP.
        start_cfg(3, 2, 1);
        run(11);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        run(8);
        chk("B_nwr", 32'(wr_cyc.size()), 32'd4);
        chk_wr("B_w3", 3, 10, 32'h01);
        chk("B_ndone", 32'(done_q.size()), 32'd0);
        chk("B_busy", 32'(busy), 32'd0);

        // Host takes the port during a sequencer ISSUE cycle.
        start_cfg(3, 2, 0);
        run(3);
        h_wvalid = 1'b1; h_waddr = 4'd0; h_wdata = 32'hAA;
        tick();
        h_wvalid = 1'b0; h_wdata = '0;
        run(8);
        chk_wr("C_host", 1, 4, 32'hAA);
        chk_wr("C_w1", 2, 5, 32'h02);
        chk_wr("C_w2", 3, 8, 32'h04);
        if (done_q.size() == 1) chk("C_done_time", 32'(done_q[0] - t0), 32'd10);
        else chk("C_ndone", 32'(done_q.size()), 32'd1);

        // Downstream rejects the LED write.
        map_size = 5'd0;
        start_cfg(3, 2, 0);
        run(4);
        map_size = 5'd3;
        chk("D_nwr", 32'(wr_cyc.size()), 32'd1);
        chk("D_nerr", 32'(err_q.size()), 32'd1);
        if (err_q.size() == 1) chk("D_err_time", 32'(err_q[0] - t0), 32'd1);
        chk("D_ndone", 32'(done_q.size()), 32'd0);
        h_wvalid = 1'b1; h_waddr = 4'd1; h_wdata = 32'h11;
        tick();
        h_waddr = 4'd7;
        tick();
        h_wvalid = 1'b0;

        // Illegal STARTs and START+STOP together are ignored.
        start_cfg(0, 2, 0);
        run(2);
        start_cfg(3, 0, 0);
        run(2);
        start_cfg(9, 2, 0);
        run(2);
        cfg_stop = 1'b1;
        start_cfg(3, 2, 0);
        cfg_stop = 1'b0;
        run(3);
        chk("E_nwr", 32'(wr_cyc.size()), 32'd0);

        // Asynchronous reset in WAIT with a non-zero step, then a restart from step 0.
        start_cfg(3, 5, 0);
        run(8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("F_busy", 32'(busy), 32'd0);
        chk("F_step", 32'(step), 32'd0);
        chk("F_done", 32'(done), 32'd0);
        chk("F_error", 32'(error), 32'd0);
        chk("F_wvalid", 32'(wvalid), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        start_cfg(2, 1, 0);
        run(5);
        chk_wr("F_restart", 0, 1, m_pat[0]);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2500; i++) begin
            idle_inputs();
            h_wvalid = ($urandom_range(0, 99) < 15);
            h_waddr  = 4'($urandom_range(0, 15));
            h_wdata  = $urandom;
            pat_we   = ($urandom_range(0, 99) < 10);
            pat_waddr = 3'($urandom_range(0, 7));
            pat_wdata = $urandom;
            cfg_start = ($urandom_range(0, 99) < 8);
            cfg_stop  = ($urandom_range(0, 99) < 2);
            cfg_loop  = 1'($urandom_range(0, 1));
            cfg_len   = 4'($urandom_range(0, 9));
            cfg_period = 16'($urandom_range(0, 6));
            map_size = ($urandom_range(0, 49) == 0) ? 5'd0 : 5'd3;
            tick();
        end
        idle_inputs();
        map_size = 5'd3;
        run(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
